// File: rtl/tmds_encoder.sv
// tmds_encoder: one channel of a DVI/HDMI TMDS 8b/10b encoder.
// Stage 1 reduces the transitions in the pixel byte to give a 9-bit word qm.
// Stage 2 chooses whether to invert qm so the link stays DC balanced, and
// tracks the running disparity. While DE is low, stage 2 emits a control
// symbol instead. Latency is two clocks, with one symbol per clock.
module tmds_encoder #(
  parameter int CNT_W = 5
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    DE,
  input  logic [7:0]              DIN,
  input  logic [1:0]              C,
  output logic [9:0]              DOUT,
  output logic signed [CNT_W-1:0] DISP
);

  // Control symbols for {C1,C0}. These are sent while the display is blanked.
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] ZERO = '0;

  // Stage 1 registers: the minimised word plus the delayed DE and C.
  logic [8:0]              qm_d, qm_q;
  logic                    de_d, de_q;
  logic [1:0]              c_d, c_q;

  // Stage 2 registers: the output symbol and the running disparity.
  logic [9:0]              dout_d, dout_q;
  logic signed [CNT_W-1:0] disp_d, disp_q;

  // Stage 1 working signals.
  logic [3:0]              din_ones;
  logic                    use_xnor;

  // Stage 2 working signals.
  logic [3:0]              qm_ones;
  logic signed [CNT_W-1:0] ones_s;
  logic signed [CNT_W-1:0] zeros_s;
  logic signed [CNT_W-1:0] bal_s;
  logic                    cnt_zero;
  logic                    cnt_pos;
  logic                    cnt_neg;
  logic                    qm_balanced;
  logic                    more_ones;
  logic                    more_zeros;

  // Stage 1: count the ones in DIN, then build qm with an XOR or an XNOR chain.
  // The XNOR chain is used when the byte is ones-heavy, to cut transitions.
  always_comb begin
    din_ones = '0;
    for (int i = 0; i < 8; i++) begin
      din_ones = din_ones + {3'b000, DIN[i]};
    end
    use_xnor = (din_ones > 4'd4) || ((din_ones == 4'd4) && !DIN[0]);

    qm_d    = '0;
    qm_d[0] = DIN[0];
    for (int i = 1; i < 8; i++) begin
      if (use_xnor) begin
        qm_d[i] = ~(qm_d[i-1] ^ DIN[i]);
      end else begin
        qm_d[i] = qm_d[i-1] ^ DIN[i];
      end
    end
    qm_d[8] = ~use_xnor;

    de_d = DE;
    c_d  = C;
  end

  // Stage 1 register. Reset leaves the stage looking like blanking with C=00.
  always_ff @(posedge CLK) begin
    if (RST) begin
      qm_q <= '0;
      de_q <= 1'b0;
      c_q  <= 2'b00;
    end else begin
      qm_q <= qm_d;
      de_q <= de_d;
      c_q  <= c_d;
    end
  end

  // Stage 2 helpers: ones and zeros in qm[7:0] as signed disparity terms.
  // Also classify the sign of the running disparity.
  always_comb begin
    qm_ones = '0;
    for (int i = 0; i < 8; i++) begin
      qm_ones = qm_ones + {3'b000, qm_q[i]};
    end
    ones_s      = $signed(CNT_W'(qm_ones));
    zeros_s     = $signed(CNT_W'(4'd8 - qm_ones));
    bal_s       = ones_s - zeros_s;
    cnt_zero    = (disp_q == ZERO);
    cnt_neg     = disp_q[CNT_W-1];
    cnt_pos     = !cnt_neg && !cnt_zero;
    qm_balanced = (qm_ones == 4'd4);
    more_ones   = (qm_ones > 4'd4);
    more_zeros  = (qm_ones < 4'd4);
  end

  // Stage 2: pick the symbol and update the running disparity.
  // Blanking always returns the disparity to zero.
  always_comb begin
    dout_d = dout_q;
    disp_d = disp_q;
    if (!de_q) begin
      unique case (c_q)
        2'b00:   dout_d = CTRL_00;
        2'b01:   dout_d = CTRL_01;
        2'b10:   dout_d = CTRL_10;
        default: dout_d = CTRL_11;
      endcase
      disp_d = ZERO;
    end else if (cnt_zero || qm_balanced) begin
      dout_d = {~qm_q[8], qm_q[8], (qm_q[8] ? qm_q[7:0] : ~qm_q[7:0])};
      if (qm_q[8]) begin
        disp_d = disp_q + bal_s;
      end else begin
        disp_d = disp_q - bal_s;
      end
    end else if ((cnt_pos && more_ones) || (cnt_neg && more_zeros)) begin
      dout_d = {1'b1, qm_q[8], ~qm_q[7:0]};
      if (qm_q[8]) begin
        disp_d = disp_q + TWO - bal_s;
      end else begin
        disp_d = disp_q - bal_s;
      end
    end else begin
      dout_d = {1'b0, qm_q[8], qm_q[7:0]};
      if (qm_q[8]) begin
        disp_d = disp_q + bal_s;
      end else begin
        disp_d = disp_q - TWO + bal_s;
      end
    end
  end

  // Stage 2 register. Reset clears both the symbol and the disparity.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_q <= '0;
      disp_q <= '0;
    end else begin
      dout_q <= dout_d;
      disp_q <= disp_d;
    end
  end

  assign DOUT = dout_q;
  assign DISP = disp_q;

endmodule
